// File: rtl/hdr_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// hdr_cmd_sequencer
//   Queues HDR commands (TID/CP/TOC/MODE) coming from the I3C engine command
//   path and drives the HDR engine with them.  Commands with TOC=0 are chained
//   back-to-back while the engine stays in HDR.  The sequencer forces an engine
//   exit on phase timeout, command underrun or abort.  Exactly one response
//   (TID + error code) is returned per launched command, in launch order.
//
// Ports
//   i_sys_clk, i_sys_rst_n        clock, asynchronous active-low reset
//   i_seq_en                      sequencer enable (falling while busy = abort)
//   i_cmd_valid / o_cmd_ready     command push handshake
//   i_cmd_tid/cp/toc/mode         command fields
//   o_hdrengine_en, o_cp, o_toc,  HDR engine controls
//   o_mode
//   i_ccc_done, i_ddr_mode_done   phase done pulses (selected by current CP)
//   i_hdrengine_done              engine exit complete
//   o_resp_valid / i_resp_ready   response pop handshake
//   o_resp_tid, o_resp_err        response head (00 OK, 01 TIMEOUT,
//                                 10 UNDERRUN, 11 ABORT)
//   o_busy                        sequencer not idle
// ----------------------------------------------------------------------------
module hdr_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int TID_W       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst_n,
    input  logic             i_seq_en,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [TID_W-1:0] i_cmd_tid,
    input  logic             i_cmd_cp,
    input  logic             i_cmd_toc,
    input  logic [2:0]       i_cmd_mode,
    output logic             o_hdrengine_en,
    output logic             o_cp,
    output logic             o_toc,
    output logic [2:0]       o_mode,
    input  logic             i_ccc_done,
    input  logic             i_ddr_mode_done,
    input  logic             i_hdrengine_done,
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [TID_W-1:0] o_resp_tid,
    output logic [1:0]       o_resp_err,
    output logic             o_busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam int CMD_W = TID_W + 5;
    localparam int RSP_W = TID_W + 2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_UNDERRUN = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_EXIT  = 2'd2,
        ST_FORCE = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;

    // Command queue entry layout: {tid, cp, toc, mode[2:0]}
    logic [CMD_W-1:0] cq_mem_r [DEPTH];
    logic [PTR_W-1:0] cq_wr_ptr_r;
    logic [PTR_W-1:0] cq_rd_ptr_r;
    logic [CNT_W-1:0] cq_cnt_r;
    logic [CMD_W-1:0] cq_head_s;

    // Response queue entry layout: {tid, err[1:0]}
    logic [RSP_W-1:0] rq_mem_r [DEPTH];
    logic [PTR_W-1:0] rq_wr_ptr_r;
    logic [PTR_W-1:0] rq_rd_ptr_r;
    logic [CNT_W-1:0] rq_cnt_r;

    logic [TID_W-1:0] cur_tid_r;
    logic             cur_cp_r;
    logic             cur_toc_r;
    logic [2:0]       cur_mode_r;
    logic [TMR_W-1:0] timer_r;

    logic [CNT_W:0]   occupancy_s;
    logic             in_flight_s;
    logic             cmd_ready_s;
    logic             cmd_push_s;
    logic             cmd_pop_s;
    logic             cq_empty_s;
    logic             resp_push_s;
    logic             resp_pop_s;
    logic [1:0]       resp_err_s;
    logic             timer_clr_s;
    logic             timer_hit_s;
    logic             phase_done_s;

    // A launched command counts against capacity until its response is
    // queued, so the response queue can never overflow.
    assign in_flight_s = (state_r == ST_RUN) || (state_r == ST_EXIT);
    assign occupancy_s = {1'b0, cq_cnt_r} + {1'b0, rq_cnt_r} + (CNT_W+1)'(in_flight_s);
    assign cmd_ready_s = (occupancy_s < (CNT_W+1)'(DEPTH));
    assign cmd_push_s  = i_cmd_valid & cmd_ready_s;
    assign cq_empty_s  = (cq_cnt_r == CNT_W'(0));
    assign cq_head_s   = cq_mem_r[cq_rd_ptr_r];
    assign resp_pop_s  = (rq_cnt_r != CNT_W'(0)) & i_resp_ready;

    // The timer starts at 0 on phase entry; the phase ends on the edge where
    // it would reach TIMEOUT_CYC-1.
    assign timer_hit_s  = (timer_r == TMR_W'(TIMEOUT_CYC - 2));
    assign phase_done_s = cur_cp_r ? i_ccc_done : i_ddr_mode_done;

    // Next-state decode: priority abort > phase done > timeout
    always_comb begin
        state_nxt_s = state_r;
        cmd_pop_s   = 1'b0;
        resp_push_s = 1'b0;
        resp_err_s  = ERR_OK;
        timer_clr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_seq_en && !cq_empty_s) begin
                    cmd_pop_s   = 1'b1;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!i_seq_en) begin
                    resp_push_s = 1'b1;
                    resp_err_s  = ERR_ABORT;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_FORCE;
                end else if (phase_done_s) begin
                    timer_clr_s = 1'b1;
                    if (cur_toc_r) begin
                        state_nxt_s = ST_EXIT;
                    end else if (!cq_empty_s) begin
                        resp_push_s = 1'b1;
                        resp_err_s  = ERR_OK;
                        cmd_pop_s   = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        resp_push_s = 1'b1;
                        resp_err_s  = ERR_UNDERRUN;
                        state_nxt_s = ST_FORCE;
                    end
                end else if (timer_hit_s) begin
                    resp_push_s = 1'b1;
                    resp_err_s  = ERR_TIMEOUT;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_FORCE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_EXIT: begin
                if (!i_seq_en) begin
                    resp_push_s = 1'b1;
                    resp_err_s  = ERR_ABORT;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_FORCE;
                end else if (i_hdrengine_done) begin
                    resp_push_s = 1'b1;
                    resp_err_s  = ERR_OK;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (timer_hit_s) begin
                    resp_push_s = 1'b1;
                    resp_err_s  = ERR_TIMEOUT;
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_FORCE;
                end else begin
                    state_nxt_s = ST_EXIT;
                end
            end
            ST_FORCE: begin
                if (i_hdrengine_done || timer_hit_s) begin
                    timer_clr_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_FORCE;
                end
            end
            default: begin
                timer_clr_s = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, current command and phase timer
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_r    <= ST_IDLE;
            cur_tid_r  <= '0;
            cur_cp_r   <= 1'b0;
            cur_toc_r  <= 1'b0;
            cur_mode_r <= 3'd0;
            timer_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (cmd_pop_s) begin
                cur_tid_r  <= cq_head_s[CMD_W-1:5];
                cur_cp_r   <= cq_head_s[4];
                cur_toc_r  <= cq_head_s[3];
                cur_mode_r <= cq_head_s[2:0];
            end
            if (timer_clr_s || (state_r == ST_IDLE)) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + TMR_W'(1);
            end
        end
    end

    // Command queue pointers and occupancy
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            cq_wr_ptr_r <= '0;
            cq_rd_ptr_r <= '0;
            cq_cnt_r    <= '0;
        end else begin
            if (cmd_push_s) begin
                cq_wr_ptr_r <= cq_wr_ptr_r + PTR_W'(1);
            end
            if (cmd_pop_s) begin
                cq_rd_ptr_r <= cq_rd_ptr_r + PTR_W'(1);
            end
            case ({cmd_push_s, cmd_pop_s})
                2'b10:   cq_cnt_r <= cq_cnt_r + CNT_W'(1);
                2'b01:   cq_cnt_r <= cq_cnt_r - CNT_W'(1);
                default: cq_cnt_r <= cq_cnt_r;
            endcase
        end
    end

    // Response queue pointers and occupancy
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            rq_wr_ptr_r <= '0;
            rq_rd_ptr_r <= '0;
            rq_cnt_r    <= '0;
        end else begin
            if (resp_push_s) begin
                rq_wr_ptr_r <= rq_wr_ptr_r + PTR_W'(1);
            end
            if (resp_pop_s) begin
                rq_rd_ptr_r <= rq_rd_ptr_r + PTR_W'(1);
            end
            case ({resp_push_s, resp_pop_s})
                2'b10:   rq_cnt_r <= rq_cnt_r + CNT_W'(1);
                2'b01:   rq_cnt_r <= rq_cnt_r - CNT_W'(1);
                default: rq_cnt_r <= rq_cnt_r;
            endcase
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge i_sys_clk) begin
        if (cmd_push_s) begin
            cq_mem_r[cq_wr_ptr_r] <= {i_cmd_tid, i_cmd_cp, i_cmd_toc, i_cmd_mode};
        end
        if (resp_push_s) begin
            rq_mem_r[rq_wr_ptr_r] <= {cur_tid_r, resp_err_s};
        end
    end

    // Engine-facing outputs, decoded only from registered state.  While
    // chaining, CP shows the next command so the engine samples it on the
    // done cycle.
    always_comb begin
        o_busy         = (state_r != ST_IDLE);
        o_hdrengine_en = (state_r != ST_IDLE);
        o_toc          = (state_r != ST_IDLE) ? cur_toc_r : 1'b0;
        if ((state_r == ST_RUN) || (state_r == ST_EXIT)) begin
            o_mode = cur_mode_r;
        end else begin
            o_mode = 3'd0;
        end
        if ((state_r == ST_RUN) && !cur_toc_r && !cq_empty_s) begin
            o_cp = cq_head_s[4];
        end else if (state_r != ST_IDLE) begin
            o_cp = cur_cp_r;
        end else begin
            o_cp = 1'b0;
        end
    end

    assign o_cmd_ready  = cmd_ready_s;
    assign o_resp_valid = (rq_cnt_r != CNT_W'(0));
    assign o_resp_tid   = o_resp_valid ? rq_mem_r[rq_rd_ptr_r][RSP_W-1:2] : '0;
    assign o_resp_err   = o_resp_valid ? rq_mem_r[rq_rd_ptr_r][1:0] : 2'b00;

endmodule

// File: tb/tb_hdr_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_hdr_cmd_sequencer
//   Directed scenarios followed by randomized command bursts.  Expected
//   responses are queued by the stimulus at the point it decides each
//   command's fate; a negedge monitor compares every popped response.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hdr_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TID_W = 4;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [3:0] tid;
        logic       cp;
        logic       toc;
        logic [2:0] mode;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       seq_en = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_tid = 4'd0;
    logic       cmd_cp = 1'b0;
    logic       cmd_toc = 1'b0;
    logic [2:0] cmd_mode = 3'd0;
    logic       hen, ocp, otoc;
    logic [2:0] omode;
    logic       ccc_done = 1'b0;
    logic       ddr_done = 1'b0;
    logic       hdr_done = 1'b0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic [3:0] resp_tid;
    logic [1:0] resp_err;
    logic       busy;

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   fail_cnt = 0;
    logic rnd_ready = 1'b0;

    cmd_t       cmd_q[$];
    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;

    always #5 clk = ~clk;

    hdr_cmd_sequencer #(.DEPTH(DEPTH), .TID_W(TID_W), .TIMEOUT_CYC(TMO)) dut (
        .i_sys_clk(clk), .i_sys_rst_n(rst_n), .i_seq_en(seq_en),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_tid(cmd_tid), .i_cmd_cp(cmd_cp), .i_cmd_toc(cmd_toc), .i_cmd_mode(cmd_mode),
        .o_hdrengine_en(hen), .o_cp(ocp), .o_toc(otoc), .o_mode(omode),
        .i_ccc_done(ccc_done), .i_ddr_mode_done(ddr_done), .i_hdrengine_done(hdr_done),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_tid(resp_tid), .o_resp_err(resp_err), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) resp_ready = 1'($urandom);
    endtask

    task automatic push(input cmd_t c);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_tid = c.tid; cmd_cp = c.cp; cmd_toc = c.toc; cmd_mode = c.mode;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("push_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!hen && n < 50) begin tick(); n++; end
        check("launch", hen, 1);
    endtask

    task automatic pulse_hdr();
        hdr_done = 1'b1; tick(); hdr_done = 1'b0;
    endtask

    task automatic force_exit();
        int d;
        check("force_mode", omode, 0);
        check("force_en", hen, 1);
        d = $urandom_range(0, 3);
        repeat (d) tick();
        pulse_hdr();
        check("force_done_en", hen, 0);
        check("force_done_busy", busy, 0);
    endtask

    // Response monitor: compares each popped response with the next expected one
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            total_cnt++;
            assert (exp_q.size() != 0) pass_cnt++;
            else begin
                fail_cnt++;
                $error("FAIL resp_extra: observed tid %0h err %0h expected none", resp_tid, resp_err);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                check("resp_tid", resp_tid, mon_exp[5:2]);
                check("resp_err", resp_err, mon_exp[1:0]);
            end
        end
    end

    initial begin
        cmd_t cur;
        int   k, d, n;
        logic exp_cp, running, abort;

        // ---------------- reset ----------------
        repeat (3) tick();
        rst_n = 1'b1;
        check("rst_en", hen, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_rv", resp_valid, 0);
        check("rst_mode", omode, 0);
        check("rst_cp", ocp, 0);
        check("rst_toc", otoc, 0);

        // ---------------- 1: single exit command ----------------
        seq_en = 1'b1; resp_ready = 1'b1;
        push('{4'd3, 1'b0, 1'b1, 3'd6});
        check("t1_latency_en", hen, 0);
        tick();
        check("t1_en", hen, 1);
        check("t1_mode", omode, 6);
        check("t1_toc", otoc, 1);
        check("t1_cp", ocp, 0);
        check("t1_busy", busy, 1);
        ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        check("t1_exit_en", hen, 1);
        check("t1_exit_rv", resp_valid, 0);
        exp_q.push_back({4'd3, 2'b00});
        pulse_hdr();
        check("t1_rv", resp_valid, 1);
        check("t1_rtid", resp_tid, 3);
        check("t1_rerr", resp_err, 0);
        check("t1_en_off", hen, 0);
        check("t1_idle", busy, 0);
        tick();
        check("t1_popped", resp_valid, 0);

        // ---------------- 2: CCC chained into DDR ----------------
        push('{4'd1, 1'b1, 1'b0, 3'd6});
        push('{4'd2, 1'b0, 1'b1, 3'd6});
        check("t2_cp_head", ocp, 0);
        check("t2_toc", otoc, 0);
        check("t2_en", hen, 1);
        ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        check("t2_ignored_toc", otoc, 0);
        check("t2_ignored_rv", resp_valid, 0);
        exp_q.push_back({4'd1, 2'b00});
        ccc_done = 1'b1; tick(); ccc_done = 1'b0;
        check("t2_chain_en", hen, 1);
        check("t2_chain_cp", ocp, 0);
        check("t2_chain_toc", otoc, 1);
        check("t2_chain_rv", resp_valid, 1);
        check("t2_chain_rtid", resp_tid, 1);
        exp_q.push_back({4'd2, 2'b00});
        ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        check("t2_exit_en", hen, 1);
        pulse_hdr();
        check("t2_en_off", hen, 0);
        check("t2_rtid", resp_tid, 2);
        tick();

        // ---------------- 3: underrun ----------------
        push('{4'd5, 1'b0, 1'b0, 3'd6});
        tick();
        check("t3_cp", ocp, 0);
        check("t3_toc", otoc, 0);
        exp_q.push_back({4'd5, 2'b10});
        ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        check("t3_rv", resp_valid, 1);
        check("t3_rtid", resp_tid, 5);
        check("t3_rerr", resp_err, 2);
        check("t3_mode", omode, 0);
        check("t3_en", hen, 1);
        repeat (2) tick();
        check("t3_hold_mode", omode, 0);
        check("t3_hold_busy", busy, 1);
        pulse_hdr();
        check("t3_idle_en", hen, 0);
        check("t3_idle", busy, 0);
        pulse_hdr();
        check("t3_hdr_ignored", busy, 0);

        // ---------------- 4: timeout in RUN, then in FORCE ----------------
        push('{4'd7, 1'b0, 1'b1, 3'd6});
        tick();
        check("t4_en", hen, 1);
        repeat (TMO - 2) tick();
        check("t4_pre_rv", resp_valid, 0);
        check("t4_pre_mode", omode, 6);
        exp_q.push_back({4'd7, 2'b01});
        tick();
        check("t4_rv", resp_valid, 1);
        check("t4_rerr", resp_err, 1);
        check("t4_mode", omode, 0);
        check("t4_force_en", hen, 1);
        repeat (TMO - 2) tick();
        check("t4_force_hold", hen, 1);
        tick();
        check("t4_force_to_en", hen, 0);
        check("t4_force_to_busy", busy, 0);
        check("t4_no_extra", resp_valid, 0);

        // ---------------- 5: capacity limit ----------------
        seq_en = 1'b0; resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push('{4'(8 + i), 1'b0, 1'b1, 3'd6});
            check("t5_ready", cmd_ready, (i < 3) ? 1 : 0);
        end
        cmd_valid = 1'b1; cmd_tid = 4'd12; cmd_cp = 1'b0; cmd_toc = 1'b1; cmd_mode = 3'd6;
        repeat (3) tick();
        check("t5_full", cmd_ready, 0);
        cmd_valid = 1'b0;
        seq_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_en();
            check("t5_mode", omode, 6);
            exp_q.push_back({4'(8 + i), 2'b00});
            ddr_done = 1'b1; tick(); ddr_done = 1'b0;
            pulse_hdr();
        end
        check("t5_rv", resp_valid, 1);
        check("t5_rtid", resp_tid, 8);
        check("t5_ready_resp_full", cmd_ready, 0);
        repeat (2) tick();
        check("t5_no_fifth", busy, 0);
        resp_ready = 1'b1;
        repeat (6) tick();
        check("t5_drained_rv", resp_valid, 0);
        check("t5_drained_ready", cmd_ready, 1);
        check("t5_drained_exp", exp_q.size(), 0);

        // ---------------- 6a: abort beats phase done ----------------
        push('{4'd4, 1'b0, 1'b1, 3'd6});
        tick();
        push('{4'd6, 1'b0, 1'b1, 3'd6});
        exp_q.push_back({4'd4, 2'b11});
        seq_en = 1'b0; ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        check("t6_rv", resp_valid, 1);
        check("t6_rtid", resp_tid, 4);
        check("t6_rerr", resp_err, 3);
        check("t6_mode", omode, 0);
        check("t6_en", hen, 1);
        pulse_hdr();
        check("t6_idle", busy, 0);
        repeat (2) tick();
        check("t6_stays_idle", busy, 0);
        seq_en = 1'b1;
        wait_en();
        check("t6_relaunch_mode", omode, 6);
        exp_q.push_back({4'd6, 2'b00});
        ddr_done = 1'b1; tick(); ddr_done = 1'b0;
        pulse_hdr();
        check("t6_done", busy, 0);
        tick();

        // ---------------- 6b: reset mid-run ----------------
        push('{4'd13, 1'b0, 1'b1, 3'd6});
        push('{4'd14, 1'b0, 1'b1, 3'd6});
        check("t6b_running", hen, 1);
        rst_n = 1'b0;
        #2;
        check("t6b_en", hen, 0);
        check("t6b_busy", busy, 0);
        check("t6b_rv", resp_valid, 0);
        check("t6b_ready", cmd_ready, 1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t6b_queue_lost", busy, 0);

        // ---------------- randomized bursts ----------------
        for (int r = 0; r < 25; r++) begin
            seq_en = 1'b0; rnd_ready = 1'b0; resp_ready = 1'b1;
            k = $urandom_range(1, 3);
            for (int j = 0; j < k; j++) begin
                cur.tid  = 4'($urandom);
                cur.cp   = 1'($urandom);
                cur.toc  = (j == k - 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
                cur.mode = 3'($urandom_range(1, 7));
                cmd_q.push_back(cur);
                push(cur);
            end
            rnd_ready = 1'b1;
            while (cmd_q.size() > 0) begin
                seq_en = 1'b1;
                wait_en();
                cur = cmd_q.pop_front();
                running = 1'b1;
                while (running) begin
                    d = $urandom_range(0, 4);
                    for (int t = 0; t <= d; t++) begin
                        exp_cp = (!cur.toc && cmd_q.size() > 0) ? cmd_q[0].cp : cur.cp;
                        check("r_en", hen, 1);
                        check("r_mode", omode, cur.mode);
                        check("r_toc", otoc, cur.toc);
                        check("r_cp", ocp, exp_cp);
                        if (t < d) begin
                            if (cur.cp) ddr_done = 1'($urandom);
                            else        ccc_done = 1'($urandom);
                            hdr_done = 1'($urandom);
                            tick();
                            ddr_done = 1'b0; ccc_done = 1'b0; hdr_done = 1'b0;
                        end
                    end
                    abort = ($urandom_range(0, 7) == 0);
                    if (abort) begin
                        exp_q.push_back({cur.tid, 2'b11});
                        seq_en = 1'b0;
                        if (cur.cp) ccc_done = 1'($urandom);
                        else        ddr_done = 1'($urandom);
                        tick();
                        ccc_done = 1'b0; ddr_done = 1'b0;
                        force_exit();
                        running = 1'b0;
                    end else begin
                        if (cur.toc) begin
                            if (cur.cp) ccc_done = 1'b1; else ddr_done = 1'b1;
                            tick();
                            ccc_done = 1'b0; ddr_done = 1'b0;
                            n = $urandom_range(0, 3);
                            for (int t = 0; t < n; t++) begin
                                check("r_exit_en", hen, 1);
                                ccc_done = 1'($urandom); ddr_done = 1'($urandom);
                                tick();
                                ccc_done = 1'b0; ddr_done = 1'b0;
                            end
                            exp_q.push_back({cur.tid, 2'b00});
                            pulse_hdr();
                            check("r_exit_done", hen, 0);
                            running = 1'b0;
                        end else if (cmd_q.size() > 0) begin
                            exp_q.push_back({cur.tid, 2'b00});
                            if (cur.cp) ccc_done = 1'b1; else ddr_done = 1'b1;
                            tick();
                            ccc_done = 1'b0; ddr_done = 1'b0;
                            cur = cmd_q.pop_front();
                            check("r_chain_en", hen, 1);
                        end else begin
                            exp_q.push_back({cur.tid, 2'b10});
                            if (cur.cp) ccc_done = 1'b1; else ddr_done = 1'b1;
                            tick();
                            ccc_done = 1'b0; ddr_done = 1'b0;
                            force_exit();
                            running = 1'b0;
                        end
                    end
                end
            end
            rnd_ready = 1'b0; resp_ready = 1'b1;
            n = 0;
            while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
            check("r_drain", exp_q.size(), 0);
            tick();
            check("r_idle", busy, 0);
            check("r_rv_empty", resp_valid, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
